// File: rtl/button_debouncer.sv
// Four-channel push-button conditioner: synchronise, debounce, and emit
// active-low levels plus one-cycle press strobes (bit 3 = left .. bit 0 = down).
module button_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic [3:0] press,
  output logic       any_pressed
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [3:0]             keys;
  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [CNT_WIDTH-1:0]   cnt_q  [4];
  logic [CNT_WIDTH-1:0]   cnt_d  [4];
  logic [3:0]             stable_q, stable_d;
  logic [3:0]             press_q, press_d;
  logic                   any_q, any_d;

  assign keys = {key_left_n, key_right_n, key_up_n, key_down_n};

  always_comb begin
    stable_d = stable_q;
    press_d  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      // Any sample matching the accepted level leaves the counter cleared.
      if (sync_q[i][SYNC_STAGES-1] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync_q[i][SYNC_STAGES-1];
          press_d[i]  = stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
    any_d = ~&stable_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        sync_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      stable_q <= '1;
      press_q  <= '0;
      any_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], keys[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      stable_q <= stable_d;
      press_q  <= press_d;
      any_q    <= any_d;
    end
  end

  assign left        = stable_q[3];
  assign right       = stable_q[2];
  assign up          = stable_q[1];
  assign down        = stable_q[0];
  assign press       = press_q;
  assign any_pressed = any_q;

endmodule
